// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the iterative multiplier
//
// Purpose : sequencer state type, index-width helper and the
//           highest-nonzero-slice helper used by the early-exit build
//           (MULT_EARLY_EXIT_EN) of mult_iter_param.
// Ports   : none (package)

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Widest operand msb_slice_idx can scan.
  localparam int MAX_W = 256;

  // Width of a counter indexing n slices; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index of the highest nonzero slice (slice bits each) among the lowest
  // n slices of v; 0 when v is zero.
  function automatic int msb_slice_idx(input logic [MAX_W-1:0] v,
                                       input int slice, input int n);
    logic [MAX_W-1:0] mask;
    int r;
    mask = (MAX_W'(1) << slice) - MAX_W'(1);
    r = 0;
    for (int k = 0; k < n; k++) begin
      if (((v >> (k * slice)) & mask) != '0) r = k;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_iter_param_slice_sel.sv
// rtl/mult_iter_param_slice_sel.sv - slice selection and partial product
//
// Purpose : picks slice idx_a_i of ma_i and slice idx_b_i of mb_i and
//           returns their unsigned SLICE_A x SLICE_B product.
// Ports   : ma_i, mb_i   operand magnitudes (WIDTH)
//           idx_a_i      slice index into ma_i (IW)
//           idx_b_i      slice index into mb_i (JW)
//           pp_o         partial product (SLICE_A+SLICE_B)

module mult_slice_sel #(
  parameter int WIDTH   = 32,
  parameter int SLICE_A = 8,
  parameter int SLICE_B = 16,
  parameter int IW      = 2,
  parameter int JW      = 1
) (
  input  logic [WIDTH-1:0]           ma_i,
  input  logic [WIDTH-1:0]           mb_i,
  input  logic [IW-1:0]              idx_a_i,
  input  logic [JW-1:0]              idx_b_i,
  output logic [SLICE_A+SLICE_B-1:0] pp_o
);

  logic [SLICE_A-1:0] sa;
  logic [SLICE_B-1:0] sb;

  always_comb begin
    sa   = SLICE_A'(ma_i >> (SLICE_A * int'(idx_a_i)));
    sb   = SLICE_B'(mb_i >> (SLICE_B * int'(idx_b_i)));
    pp_o = {{SLICE_B{1'b0}}, sa} * {{SLICE_A{1'b0}}, sb};
  end

endmodule

// File: rtl/mult_iter_param.sv
// rtl/mult_iter_param.sv - parametrised iterative signed/unsigned multiplier
//
// Purpose : multiplies a by b over NA*NB cycles by accumulating
//           SLICE_A x SLICE_B partial products on operand magnitudes, then
//           applies the sign in a final cycle. With MULT_EARLY_EXIT_EN
//           defined, slices above the highest nonzero one are skipped.
// Ports   : clk        rising-edge clock
//           reset      synchronous active-high reset
//           start      begin an operation (accepted only in IDLE)
//           is_signed  two's-complement operands, sampled with start
//           a, b       operands (WIDTH), sampled with start
//           busy       operation in progress
//           done       one-cycle pulse, product final
//           product    result register (2*WIDTH)

module mult_iter_param
  import mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_A = 8,
  parameter int SLICE_B = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int NA  = WIDTH / SLICE_A;
  localparam int NB  = WIDTH / SLICE_B;
  localparam int IW  = idx_w(NA);
  localparam int JW  = idx_w(NB);
  localparam int PW  = 2 * WIDTH;
  localparam int PPW = SLICE_A + SLICE_B;

  state_e           state_q;
  logic [WIDTH-1:0] ma_q, mb_q;
  logic             neg_q;
  logic [IW-1:0]    i_q;
  logic [JW-1:0]    j_q;
  logic [PW-1:0]    product_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [IW-1:0]    i_lim;
  logic [JW-1:0]    j_lim;
  logic [PPW-1:0]   pp;
  logic [PW-1:0]    pp_shifted;

`ifdef MULT_EARLY_EXIT_EN
  logic [IW-1:0] ia_max_q;
  logic [JW-1:0] jb_max_q;
`endif

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    abs_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
`ifdef MULT_EARLY_EXIT_EN
    i_lim = ia_max_q;
    j_lim = jb_max_q;
`else
    i_lim = IW'(NA - 1);
    j_lim = JW'(NB - 1);
`endif
    pp_shifted = PW'(pp) << (SLICE_A * int'(i_q) + SLICE_B * int'(j_q));
  end

  mult_slice_sel #(
    .WIDTH  (WIDTH),
    .SLICE_A(SLICE_A),
    .SLICE_B(SLICE_B),
    .IW     (IW),
    .JW     (JW)
  ) u_slice_sel (
    .ma_i   (ma_q),
    .mb_i   (mb_q),
    .idx_a_i(i_q),
    .idx_b_i(j_q),
    .pp_o   (pp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      neg_q     <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULT_EARLY_EXIT_EN
      ia_max_q  <= '0;
      jb_max_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ma_q      <= abs_a;
            mb_q      <= abs_b;
            neg_q     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
`ifdef MULT_EARLY_EXIT_EN
            ia_max_q  <= IW'(msb_slice_idx(MAX_W'(abs_a), SLICE_A, NA));
            jb_max_q  <= JW'(msb_slice_idx(MAX_W'(abs_b), SLICE_B, NB));
`endif
          end
        end
        RUN: begin
          product_q <= product_q + pp_shifted;
          // j is the inner index; wrapping it advances i.
          if (j_q == j_lim) begin
            j_q <= '0;
            if (i_q == i_lim) state_q <= FIN;
            else              i_q     <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        FIN: begin
          if (neg_q) product_q <= ~product_q + 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// tb/tb_mult_iter_param.sv - randomized self-checking bench for mult_iter_param
//
// Purpose : drives directed and random operations into mult_iter_param
//           (defaults WIDTH=32, SLICE_A=8, SLICE_B=16) and compares product,
//           busy length and done against an arithmetic reference model.
//           Busy-length expectations follow MULT_EARLY_EXIT_EN when defined.
// Ports   : none

module tb_mult_iter_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  mult_iter_param #(
    .WIDTH  (32),
    .SLICE_A(8),
    .SLICE_B(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
    longint px, py;
    if (sgn) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'({32'd0, x});
      py = longint'({32'd0, y});
    end
    return 64'(px * py);
  endfunction

  // Cycles busy stays high: number of slice steps plus the sign cycle.
  function automatic int ref_busy(input logic [31:0] x, input logic [31:0] y,
                                  input logic sgn);
    longint vx, vy;
    int ia = 0;
    int jb = 0;
    int steps;
    vx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    vy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    if (vx < 0) vx = -vx;
    if (vy < 0) vy = -vy;
    for (int k = 0; k < 4; k++) if (((vx >> (8 * k)) % 256) != 0) ia = k;
    for (int k = 0; k < 2; k++) if (((vy >> (16 * k)) % 65536) != 0) jb = k;
`ifdef MULT_EARLY_EXIT_EN
    steps = (ia + 1) * (jb + 1);
`else
    steps = 4 * 2 + 0 * (ia + jb);
`endif
    return steps + 1;
  endfunction

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    a = x;
    b = y;
    is_signed = sgn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy cycles after launch; optionally pulses a stray start at cycle inj.
  task automatic finish_op(input string tag, input logic [63:0] exp_p,
                           input int exp_busy, input int inj);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == inj) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " product"}, product, exp_p);
  endtask

  task automatic idle_check(input string tag, input logic [63:0] exp_p);
    @(posedge clk); #1;
    check({tag, " done_drop"}, 64'(done), 64'd0);
    check({tag, " busy_idle"}, 64'(busy), 64'd0);
    check({tag, " hold"}, product, exp_p);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] edges [5];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'hFFFF_FFFF;
    edges[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 255));
      1:       return 32'($urandom_range(0, 65535));
      2:       return edges[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    logic        s;
    int          t4_busy, t4z_busy;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    finish_op("t1", 64'hFFFF_FFFE_0000_0001, 9, 0);
    idle_check("t1", 64'hFFFF_FFFE_0000_0001);

    launch(32'hFFFF_FFFD, 32'd7, 1'b1);
    finish_op("t2s", 64'hFFFF_FFFF_FFFF_FFEB, ref_busy(32'hFFFF_FFFD, 32'd7, 1'b1), 0);
    launch(32'hFFFF_FFFD, 32'd7, 1'b0);
    finish_op("t2u", 64'h0000_0006_FFFF_FFEB, ref_busy(32'hFFFF_FFFD, 32'd7, 1'b0), 0);
    idle_check("t2u", 64'h0000_0006_FFFF_FFEB);

    launch(32'h8000_0000, 32'h8000_0000, 1'b1);
    finish_op("t3a", 64'h4000_0000_0000_0000, ref_busy(32'h8000_0000, 32'h8000_0000, 1'b1), 0);
    launch(32'h8000_0000, 32'd1, 1'b1);
    finish_op("t3b", 64'hFFFF_FFFF_8000_0000, ref_busy(32'h8000_0000, 32'd1, 1'b1), 0);
    idle_check("t3b", 64'hFFFF_FFFF_8000_0000);

`ifdef MULT_EARLY_EXIT_EN
    t4_busy  = 3;
    t4z_busy = 2;
`else
    t4_busy  = 9;
    t4z_busy = 9;
`endif
    launch(32'd25585, 32'd41529, 1'b0);
    finish_op("t4", 64'd1062519465, t4_busy, 0);
    idle_check("t4", 64'd1062519465);
    launch(32'd0, 32'd41529, 1'b0);
    finish_op("t4z", 64'd0, t4z_busy, 0);
    idle_check("t4z", 64'd0);

    launch(32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
    finish_op("t5", ref_mul(32'h1234_5678, 32'h9ABC_DEF1, 1'b0), 9, 3);
    idle_check("t5", ref_mul(32'h1234_5678, 32'h9ABC_DEF1, 1'b0));

    launch(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    a = 32'd3;
    b = 32'd5;
    @(posedge clk); #1;
    check("t6 busy", 64'(busy), 64'd0);
    check("t6 done", 64'(done), 64'd0);
    check("t6 product", product, 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("t6 no_start", 64'(busy), 64'd0);
    launch(32'hFFFF_FFF0, 32'h0001_0003, 1'b1);
    finish_op("t6 after", ref_mul(32'hFFFF_FFF0, 32'h0001_0003, 1'b1),
              ref_busy(32'hFFFF_FFF0, 32'h0001_0003, 1'b1), 0);

    for (int k = 0; k < 24; k++) begin
      x = rand_operand();
      y = rand_operand();
      s = 1'($urandom_range(0, 1));
      launch(x, y, s);
      finish_op($sformatf("rnd%0d", k), ref_mul(x, y, s), ref_busy(x, y, s), 0);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", k), ref_mul(x, y, s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_iter_param.md
Name: mult_iter_param

Overview:
- Parametrised iterative multi-cycle multiplier; successor to the fixed 32x32 fast multiplier.
- Generalises operand width and partial-product slice widths.
- Adds a per-operation signed/unsigned mode and a done pulse.
- Used by datapath blocks that issue start and then wait on busy or done.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- SLICE_A, 8, bits of a consumed per step; WIDTH must be a multiple of SLICE_A.
- SLICE_B, 16, bits of b consumed per step; WIDTH must be a multiple of SLICE_B.
- Derived: NA = WIDTH/SLICE_A and NB = WIDTH/SLICE_B; full step count NA*NB (default 8).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin an operation; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands; sampled with start
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when the product is final
- product  out  2*WIDTH  result register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- Reset mid-operation aborts the operation; start asserted in the same cycle as reset is ignored.
- States: IDLE, RUN, FIN.
- IDLE, rising edge with start=1:
  - Latch magnitudes ma=|a| and mb=|b| (magnitude applies when is_signed=1; otherwise raw values).
  - Latch neg = is_signed & (a[MSB]^b[MSB]).
  - product<=0, i=0, j=0, busy<=1, done<=0, next state RUN.
- IDLE with start=0: done<=0; product holds its last value.
- RUN, each edge:
  - product += (ma slice i * mb slice j) << (i*SLICE_A + j*SLICE_B).
  - The partial product is SLICE_A+SLICE_B bits unsigned; accumulation is mod 2^(2*WIDTH).
  - j is the inner index, i the outer.
  - On the edge that performs the last step, next state is FIN.
- FIN, one edge:
  - If neg, product <= -product (two's complement).
  - busy<=0, done<=1, next state IDLE.
- Latency: busy is high for steps+1 cycles (default 9); done is high for exactly 1 cycle, in the first IDLE cycle.
- Product is valid while done=1 and holds until the next accepted start.
- start while busy=1 is ignored and does not alter a, b or mode.
- start in the same cycle done=1 (state IDLE) is accepted: back-to-back operation.
- Edge values:
  - Signed -2^(WIDTH-1): its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - -2^(W-1) * -2^(W-1) = 2^(2W-2), which is representable.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - At start, compute ia_max = index of the highest nonzero SLICE_A slice of ma (0 if ma=0).
  - Likewise jb_max for mb.
  - RUN iterates only i<=ia_max, j<=jb_max; steps = (ia_max+1)*(jb_max+1).
  - busy lasts steps+1 cycles.
  - Product value is identical to the full iteration.
- Undefined: always NA*NB steps; ia_max and jb_max logic is absent.

Decomposition:
- Package mult_pkg:
  - state enum (IDLE, RUN, FIN).
  - Function clog2-based index widths.
  - Function msb_slice_idx (used under the macro).
- Sub-module mult_slice_sel: combinational selection of slice i of ma and slice j of mb plus their SLICE_A x SLICE_B product. It is instantiated once.
- All sequencing stays in mult_iter_param.

Test Plan:
Defaults WIDTH=32, SLICE_A=8, SLICE_B=16; cycles are counted from the edge that samples start.
1. Unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; busy high 9 cycles (macro off); done 1 cycle.
2. a=0xFFFFFFFD, b=7:
   - signed -> 0xFFFFFFFFFFFFFFEB (-21).
   - unsigned -> 0x00000006FFFFFFEB.
   - Issued back-to-back, with the second start in the done cycle.
3. Signed a=b=0x80000000 -> 0x4000000000000000. Also signed a=0x80000000, b=1 -> 0xFFFFFFFF80000000.
4. Unsigned a=25585, b=41529 -> 1062519465.
   - Macro on: busy 3 cycles (2 steps).
   - Macro off: 9 cycles.
   - Macro on, a=0: busy 2 cycles, product 0.
5. start pulsed again 3 cycles into an operation with different a and b -> ignored; the first result is correct and busy length is unchanged.
6. reset asserted 4 cycles into an operation -> next cycle busy=0, done=0, product=0; a new start afterwards completes correctly.
